dmem_resp: RTL
==============

# dmem_resp

Data-memory responder serving the pipelined RV32I core's MEM-stage port: accepts the core's read/write strobes, address, store data and access type, performs byte/half/word accesses on an internal word RAM, and returns load data sign- or zero-extended. It also flags misaligned, illegal and out-of-range accesses and, optionally, exposes a small memory-mapped counter block. It sits between the core's `mem_r`/`mem_w`/`Addr_out`/`Data_out` outputs and its `Data_in` input.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two; valid byte range is 0 to 4*DEPTH_WORDS-1.
- `MMIO_BASE`, 32'hFFFF_0000: base of the 16-byte MMIO window; used only with the `DMEM_MMIO_EN` macro defined.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `mem_r` in 1: load request this cycle.
- `mem_w` in 1: store request this cycle.
- `addr` in 32: byte address.
- `wdata` in 32: store data, LSB-aligned.
- `dmtype` in 3: funct3 of the access: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `rdata` out 32: registered load result.
- `fault` out 1: sticky access-fault flag.
- `fault_addr` out 32: address of the first faulting access since the flag was last cleared.

## Operation
- Request present when `mem_r` or `mem_w` is high at the rising edge. Idle cycles leave the RAM untouched and set `rdata` to 0.
- Loads: read the word at `addr[31:2]` and select the lane from `addr[1:0]`.
  - b: sign-extend bit 7. bu: zero-extend.
  - h: lane `addr[1]`, sign-extend bit 15. hu: zero-extend.
  - w: full word.
- Stores: accept only b/h/w. Write `wdata[7:0]` to byte lane `addr[1:0]`, or `wdata[15:0]` to half lane `addr[1]`, or the full word. Other bytes are preserved via per-byte enables.
- Fault conditions (any one):
  - h/hu with `addr[0]`=1.
  - w with `addr[1:0]`≠0.
  - Store with `dmtype` bu/hu or any unlisted encoding.
  - Load with an unlisted encoding.
  - Address outside the RAM and not in an enabled MMIO window.
  - `mem_r` and `mem_w` both high.
- On a faulting access: no RAM write; `rdata`=0; `fault` set. If `fault` was 0, `fault_addr` latches `addr`; later faults do not overwrite it.
- `fault` and `fault_addr` stay until reset, or until cleared through MMIO.

## Timing
- Request sampled at rising edge N. The core drives MEM-stage signals from its falling-edge pipeline registers, so they are stable at N.
- `rdata` is valid from edge N until edge N+1, so the core captures it on the falling edge between them.
- Store commits at edge N. A load of the same address at edge N+1 returns the new value (no bypass needed).
- Back-to-back accesses are supported every cycle; no stall output.
- Reset asserted: `rdata`=0, `fault`=0, `fault_addr`=0, MMIO counters 0. RAM contents are not reset.
- Reset deasserting mid-access: the first request is the one sampled at the first rising edge with `rstn`=1.

## Configuration
- `DMEM_MMIO_EN` defined: window `MMIO_BASE`..+0xF is decoded as word-only, aligned registers. Non-word or misaligned access to the window faults.
  - +0x0 cycle counter: read-only, increments every cycle, wraps at 2^32.
  - +0x4 load count: read-only, successful loads only, wraps.
  - +0x8 store count: read-only, successful stores only, wraps.
  - +0xC fault control: read returns {31'b0, fault}; any word write clears `fault` and `fault_addr` at that edge. If a fault occurs in the same cycle, the fault wins.
  - Writes to +0x0..+0x8 are ignored without fault.
  - MMIO accesses do not touch the RAM.
- Not defined: no counters, no MMIO logic. Window addresses fault as out of range.

## Test plan
- sw 0x8040_2010 @0x10, then lb @0x12 -> `rdata`=0x0000_0040; lb @0x13 -> 0xFFFF_FF80; lhu @0x12 -> 0x0000_8040; lh @0x12 -> 0xFFFF_8040.
- sw 0xFFFF_FFFF @0x20, then sb 0x5A @0x21, then lw @0x20 -> 0xFFFF_5AFF; then sh 0x1234 @0x22, lw @0x20 -> 0x1234_5AFF.
- lw @0x06 -> `rdata`=0, `fault`=1, `fault_addr`=0x06. Then sh @0x31 -> `fault_addr` stays 0x06, no write at 0x30.
- Both `mem_r` and `mem_w` high, with `addr`=0x40 and `wdata`=0x1111_1111 -> fault; a following lw @0x40 returns the prior value.
- MMIO enabled: 3 loads, 2 stores, 1 faulting load -> lw +0x4 returns 3 (the lw itself counts after its read), +0x8 returns 2. sw +0xC -> `fault`=0, `fault_addr`=0.
- Pulse `rstn` low during a store stream -> outputs 0 immediately (asynchronous). The first post-reset lw of a previously written address returns the written data.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder for the RV32I MEM stage: byte/half/word loads and stores with sticky fault capture.
// Define DMEM_MMIO_EN to add the 16-byte MMIO window (cycle/load/store counters, fault clear).
module dmem_resp #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dmtype,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] fault_addr
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic          req, in_ram, in_mmio, type_bad, misaligned, fault_now;
  logic          ld_ok, st_ok, ram_we;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word, ld_val, wr_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [3:0]    be;

`ifdef DMEM_MMIO_EN
  logic [31:0] cyc_q, cyc_d, ldc_q, ldc_d, stc_q, stc_d;
  assign in_mmio = (addr[31:4] == MMIO_BASE[31:4]);
`else
  logic unused_mmio_base;
  assign unused_mmio_base = ^MMIO_BASE;
  assign in_mmio = 1'b0;
`endif

  always_comb begin
    req    = mem_r | mem_w;
    in_ram = ((addr >> (AW + 2)) == 32'd0);
    if (mem_r)
      type_bad = !(dmtype inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      type_bad = !(dmtype inside {3'b000, 3'b001, 3'b010});
    // MMIO registers are word-only; unlisted encodings are already caught by type_bad
    misaligned = (dmtype[1:0] == 2'b01 && addr[0])
              || (dmtype[1:0] == 2'b10 && addr[1:0] != 2'b00)
              || (in_mmio && dmtype != 3'b010);
    fault_now = req && ((mem_r && mem_w) || type_bad || misaligned || !(in_ram || in_mmio));
    ld_ok     = mem_r && !fault_now;
    st_ok     = mem_w && !fault_now;
    ram_we    = st_ok && !in_mmio && rstn;
  end

  always_comb begin
    idx     = addr[AW+1:2];
    rd_word = ram[idx];
    ld_byte = rd_word[{addr[1:0], 3'b000} +: 8];
    ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (dmtype)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = rd_word;
    endcase
`ifdef DMEM_MMIO_EN
    if (in_mmio) begin
      case (addr[3:2])
        2'b00:   ld_val = cyc_q;
        2'b01:   ld_val = ldc_q;
        2'b10:   ld_val = stc_q;
        default: ld_val = {31'b0, fault_q};
      endcase
    end
`endif
    rdata_d = ld_ok ? ld_val : 32'd0;
  end

  always_comb begin
    case (dmtype[1:0])
      2'b00: begin
        be      = 4'b0001 << addr[1:0];
        wr_word = {4{wdata[7:0]}};
      end
      2'b01: begin
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        wr_word = wdata;
      end
    endcase
  end

  // First fault since the last clear owns fault_addr; a fault beats a clear
  always_comb begin
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    if (fault_now) begin
      fault_d = 1'b1;
      if (!fault_q) fault_addr_d = addr;
    end
`ifdef DMEM_MMIO_EN
    else if (st_ok && in_mmio && addr[3:2] == 2'b11) begin
      fault_d      = 1'b0;
      fault_addr_d = 32'd0;
    end
    cyc_d = cyc_q + 32'd1;
    ldc_d = ldc_q + 32'(ld_ok);
    stc_d = stc_q + 32'(st_ok);
`endif
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ram[idx][8*i +: 8] <= wr_word[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q      <= 32'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
`ifdef DMEM_MMIO_EN
      cyc_q        <= 32'd0;
      ldc_q        <= 32'd0;
      stc_q        <= 32'd0;
`endif
    end else begin
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
`ifdef DMEM_MMIO_EN
      cyc_q        <= cyc_d;
      ldc_q        <= ldc_d;
      stc_q        <= stc_d;
`endif
    end
  end

  assign rdata      = rdata_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
endmodule
